pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Sequences the 4-stage pipeline (IF, DOF, EX, WB) around the instruction decoder's control word.
- Detects read-after-write hazards between the instruction in DOF and older instructions still in EX/WB, and stalls by holding PC/IR and injecting a bubble into EX.
- Resolves branches/jumps in EX and squashes the younger IF/DOF instructions.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width (DA/AA/BA)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- dof_valid  in  1  DOF holds a real instruction
- dof_aa  in  REG_AW  A-read address of DOF instruction
- dof_ba  in  REG_AW  B-read address of DOF instruction
- dof_ma  in  1  1 = A operand is PC, no register read
- dof_mb  in  1  1 = B operand is constant, no register read
- dof_rw  in  1  DOF instruction writes the register file
- dof_da  in  REG_AW  DOF destination address
- dof_bs  in  2  DOF branch select (00 none, 01 cond, 10 JMR, 11 JMP/JML)
- dof_ps  in  1  DOF polarity (0 = BZ, 1 = BNZ)
- ex_zero  in  1  Z flag of the ALU result currently in EX
- pc_hold  out  1  hold PC this cycle
- ir_hold  out  1  hold IR/DOF register this cycle
- ex_bubble  out  1  load NOP control into DOF->EX register
- ir_flush  out  1  load NOP into IR (squash IF instruction)
- branch_taken  out  1  select branch/jump target for PC
- stall_cnt  out  CNT_W  cycles stalled, saturating
- flush_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Reset: all outputs 0. Internal EX slot {ex_v, ex_rw, ex_da, ex_bs, ex_ps} and WB slot {wb_v, wb_rw, wb_da} are cleared (invalid). Counters are 0. Reset mid-stall or mid-flush drops all pending state.
- Source-read needs: need_a = dof_valid & ~dof_ma & (dof_aa != 0); need_b = dof_valid & ~dof_mb & (dof_ba != 0). R0 never creates a hazard.
- Hazard: (need_a & dof_aa matches an outstanding destination) | (need_b & dof_ba matches an outstanding destination).
  - An outstanding destination is ex_da with ex_v & ex_rw, or wb_da with wb_v & wb_rw.
  - The register file has no write-through, so a WB match also stalls.
- Taken branch (combinational from the EX slot, ex_v required):
  - ex_bs=01: taken if ex_zero ^ ex_ps.
  - ex_bs=10 or 11: always taken.
- Outputs, combinational in the same cycle:
  - taken: branch_taken=1, ir_flush=1, ex_bubble=1, pc_hold=0, ir_hold=0. Branch has priority over hazard, because the stalled instruction is squashed.
  - hazard & ~taken: pc_hold=1, ir_hold=1, ex_bubble=1.
  - otherwise: all 0.
- Slot update on each rising edge:
  - WB slot <= EX slot.
  - EX slot <= bubble (v=0) if ex_bubble, else {dof_valid, dof_rw, dof_da, dof_bs, dof_ps}.
- Latency: a dependent instruction stalls 2 cycles behind its producer, 1 cycle if one independent instruction intervenes. Branch penalty is 2 squashed instructions.
- JML writes its destination via the EX slot, so it is tracked like any writer.
- Counters:
  - stall_cnt increments on every cycle with hazard & ~taken.
  - flush_cnt increments on every cycle with taken.
  - Both saturate at all-ones with no wrap.

Decomposition:
- Package pipeline_pkg: BS encodings (BS_NONE, BS_COND, BS_JMR, BS_JUMP), R0 address constant, REG_AW default, slot struct typedef.
- One sub-module, hazard_compare: purely combinational 2-source x 2-destination address matcher with R0 and enable masking, instantiated once.

Test Plan:
- ADD R3,R1,R2 then ADD R4,R3,R5 back-to-back -> pc_hold/ir_hold/ex_bubble high for 2 cycles, stall_cnt=2, second ADD then enters EX.
- ADD R3 then independent instr then SUB R6,R3,R1 -> exactly 1 stall cycle; ADI R7,R3,#5 (MB=1) reading R3 via A still stalls; reading R3 only via B with MB=1 -> no stall.
- Writer to R0 followed by reader of R0 -> no stall, stall_cnt stays 0.
- BZ with PS=0 reaching EX, ex_zero=1 -> branch_taken, ir_flush, ex_bubble for 1 cycle, flush_cnt=1. With ex_zero=0 -> no flush. BNZ gives the inverse results.
- JMP in EX while the DOF instruction has a RAW hazard -> branch wins: pc_hold=0, stall_cnt unchanged, flush_cnt+1.
- Assert rst during an active stall -> all outputs 0 immediately. The next instruction after release has no hazard against pre-reset writers. Force stall_cnt to all-ones -> it holds at all-ones.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 4-stage pipeline hazard controller.
//   bs_e           : branch-select encoding carried by the decoder control word
//   R0_ADDR        : hard-wired zero register; never a real dependency
//   REG_AW_DEFAULT : default register address width (DA/AA/BA)
//   slot_t         : control fields tracked for an instruction in EX
package pipeline_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int R0_ADDR        = 0;

  typedef enum logic [1:0] {
    BS_NONE = 2'b00,
    BS_COND = 2'b01,
    BS_JMR  = 2'b10,
    BS_JUMP = 2'b11
  } bs_e;

  typedef struct packed {
    logic                      v;
    logic                      rw;
    logic [REG_AW_DEFAULT-1:0] da;
    bs_e                       bs;
    logic                      ps;
  } slot_t;

endpackage

// File: rtl/pipeline_hazard_controller_compare.sv
// hazard_compare: combinational 2-source x 2-destination address matcher.
//   src_a/src_b     : source read addresses, src_*_en qualifies a real read
//   dst0/dst1       : outstanding destination addresses, dst*_en qualifies a real write
//   hit             : some enabled, non-R0 source matches some enabled destination
module hazard_compare
  import pipeline_pkg::*;
#(
  parameter int AW = REG_AW_DEFAULT
) (
  input  logic [AW-1:0] src_a,
  input  logic          src_a_en,
  input  logic [AW-1:0] src_b,
  input  logic          src_b_en,
  input  logic [AW-1:0] dst0,
  input  logic          dst0_en,
  input  logic [AW-1:0] dst1,
  input  logic          dst1_en,
  output logic          hit
);

  logic a_live, b_live;
  logic a_hit, b_hit;

  // R0 reads as constant zero, so it can never depend on an older write.
  assign a_live = src_a_en & (src_a != AW'(R0_ADDR));
  assign b_live = src_b_en & (src_b != AW'(R0_ADDR));

  assign a_hit = (dst0_en & (src_a == dst0)) | (dst1_en & (src_a == dst1));
  assign b_hit = (dst0_en & (src_b == dst0)) | (dst1_en & (src_b == dst1));

  assign hit = (a_live & a_hit) | (b_live & b_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencing for the IF/DOF/EX/WB pipeline.
//   Inputs : DOF control word (dof_*), EX zero flag (ex_zero)
//   Outputs: pc_hold/ir_hold/ex_bubble for RAW stalls, ir_flush/branch_taken
//            for branches resolved in EX, saturating stall_cnt/flush_cnt.
//   The EX and WB slots mirror the control fields of the instructions that
//   are still ahead of DOF, which is all the hazard detection needs.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dof_valid,
  input  logic [REG_AW-1:0] dof_aa,
  input  logic [REG_AW-1:0] dof_ba,
  input  logic              dof_ma,
  input  logic              dof_mb,
  input  logic              dof_rw,
  input  logic [REG_AW-1:0] dof_da,
  input  logic [1:0]        dof_bs,
  input  logic              dof_ps,
  input  logic              ex_zero,
  output logic              pc_hold,
  output logic              ir_hold,
  output logic              ex_bubble,
  output logic              ir_flush,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              ex_v, ex_rw, ex_ps;
  logic [REG_AW-1:0] ex_da;
  bs_e               ex_bs;
  logic              wb_v, wb_rw;
  logic [REG_AW-1:0] wb_da;
  logic              hazard, taken;

  // WB still counts as outstanding: the register file has no write-through.
  hazard_compare #(.AW(REG_AW)) u_cmp (
    .src_a    (dof_aa),
    .src_a_en (dof_valid & ~dof_ma),
    .src_b    (dof_ba),
    .src_b_en (dof_valid & ~dof_mb),
    .dst0     (ex_da),
    .dst0_en  (ex_v & ex_rw),
    .dst1     (wb_da),
    .dst1_en  (wb_v & wb_rw),
    .hit      (hazard)
  );

  always_comb begin
    taken = 1'b0;
    if (ex_v) begin
      case (ex_bs)
        BS_COND:         taken = ex_zero ^ ex_ps;
        BS_JMR, BS_JUMP: taken = 1'b1;
        default:         taken = 1'b0;
      endcase
    end
  end

  // A taken branch squashes the DOF instruction, so any hazard it has is moot.
  always_comb begin
    pc_hold      = 1'b0;
    ir_hold      = 1'b0;
    ex_bubble    = 1'b0;
    ir_flush     = 1'b0;
    branch_taken = 1'b0;
    if (taken) begin
      branch_taken = 1'b1;
      ir_flush     = 1'b1;
      ex_bubble    = 1'b1;
    end else if (hazard) begin
      pc_hold   = 1'b1;
      ir_hold   = 1'b1;
      ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v  <= 1'b0;
      ex_rw <= 1'b0;
      ex_da <= '0;
      ex_bs <= BS_NONE;
      ex_ps <= 1'b0;
      wb_v  <= 1'b0;
      wb_rw <= 1'b0;
      wb_da <= '0;
    end else begin
      wb_v  <= ex_v;
      wb_rw <= ex_rw;
      wb_da <= ex_da;
      if (ex_bubble) begin
        ex_v  <= 1'b0;
        ex_rw <= 1'b0;
        ex_da <= '0;
        ex_bs <= BS_NONE;
        ex_ps <= 1'b0;
      end else begin
        ex_v  <= dof_valid;
        ex_rw <= dof_rw;
        ex_da <= dof_da;
        ex_bs <= bs_e'(dof_bs);
        ex_ps <= dof_ps;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && !taken && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (taken && (flush_cnt != '1))            flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
